spart_rx: RTL
=============

// Module: spart_rx
// PURPOSE
//  Receive half of the SPART: deserialises an async 8N1 line (idle high, start 0, 8 data LSB-first, stop 1)
//  into a byte register for the bus-side interface. Shares the 16x-baud 'enable' tick and the iocs/iorw/ioaddr
//  bus with the transmit half; rx is the far end's tx. Flags byte-ready, framing error and overrun.
// PARAMETERS
//  OVERSAMPLE  16  enable ticks per bit period (power of 2, >=4)
//  SYNC_STAGES 2   flops in rx metastability synchroniser (>=2)
// PORTS
//  clk      in   1  system clock
//  rst_n    in   1  reset, asynchronous, active-low
//  enable   in   1  one-cycle pulse at OVERSAMPLE x baud, from baud generator
//  rx       in   1  asynchronous serial input
//  iocs     in   1  chip select
//  iorw     in   1  1 = read, 0 = write
//  ioaddr   in   2  00 = data register, 01 = status register
//  rx_data  out  8  last received byte (holding register)
//  rda      out  1  receive data available
//  ferr     out  1  sticky framing error (stop bit sampled 0)
//  oerr     out  1  sticky overrun (byte completed while rda already 1)
// BEHAVIOUR
//  Reset: state IDLE, sync flops 1, rx_data 8'h00, rda 0, ferr 0, oerr 0, tick/bit counters 0.
//  rx passes through SYNC_STAGES flops -> rx_s; all decisions use rx_s only (latency SYNC_STAGES clk).
//  Tick counter advances only on enable; counters clear on every state transition.
//  States:
//   IDLE  : rx_s==0 on any clk -> START (tick cnt 0). Otherwise stay.
//   START : at OVERSAMPLE/2 enables (mid start bit) sample rx_s: 0 -> DATA, tick cnt 0, bit cnt 0;
//           1 -> false start, back to IDLE, no flags change.
//   DATA  : every OVERSAMPLE enables sample rx_s into shift reg MSB, shift right (LSB first);
//           bit cnt +1; after 8th sample -> STOP.
//   STOP  : after OVERSAMPLE enables sample rx_s (mid stop bit):
//           complete: rx_data <= shift reg, rda <= 1 on next clk; if rx_s==0 also ferr <= 1;
//           if rda was already 1 (and no same-cycle data read) oerr <= 1, rx_data still overwritten.
//           -> IDLE. A still-low line in IDLE after ferr restarts reception (break = repeated ferr bytes).
//  Bus reads (registered side effects, data combinational on rx_data/status ports):
//   iocs&&iorw&&ioaddr==00 : rda <= 0 next clk.
//   iocs&&iorw&&ioaddr==01 : ferr <= 0, oerr <= 0 next clk.
//   Writes (iorw==0) and ioaddr 10/11 have no effect on this block.
//  Simultaneous events:
//   data read same clk as byte completion -> completion wins: rda stays 1, rx_data new byte, no oerr.
//   status read same clk as new ferr/oerr -> set wins, flag stays 1.
//  enable absent: FSM holds state/counters indefinitely (except IDLE->START on rx_s low).
//  Reset mid-frame: immediate return to IDLE, partial byte discarded, flags cleared; resynchronises on
//  next falling edge; the remainder of an interrupted frame may produce one ferr byte (accepted).
//  Throughput: back-to-back frames with 1 stop bit received without loss (IDLE entered mid stop bit).
// TESTING
//  1. Send 8'hA5 8N1 at enable every 4 clk -> rx_data=8'hA5, rda=1 ~160 enables after start edge, ferr=oerr=0.
//  2. rx low for 4 enables then high -> false start, state IDLE, rda=0, no flags.
//  3. Send 8'h3C with stop bit 0 -> rx_data=8'h3C, rda=1, ferr=1; status read -> ferr=0 next clk.
//  4. Send 8'h11 then 8'h22 back-to-back without reading -> rx_data=8'h22, rda=1, oerr=1.
//  5. Data read on exact clk byte 8'h77 completes -> rda=1, rx_data=8'h77, oerr=0.
//  6. Assert rst_n low at bit 4 of 8'hFF, release -> all outputs reset; next frame 8'h5A received cleanly.

Source files
------------

// File: rtl/spart_rx_if.sv
// Bus-side view of the SPART receiver: chip select / direction / address in,
// holding register and status flags out.
interface spart_rx_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic [7:0] rx_data;
  logic       rda;
  logic       ferr;
  logic       oerr;

  modport master (
    output iocs, iorw, ioaddr,
    input  rx_data, rda, ferr, oerr
  );

  modport slave (
    input  iocs, iorw, ioaddr,
    output rx_data, rda, ferr, oerr
  );
endinterface

// File: rtl/spart_rx.sv
// SPART receive half: oversampled 8N1 deserialiser with byte-ready, framing
// error and overrun flags, cleared by bus reads of the data/status registers.
//
// Bus handshake: a read is a single clk with iocs=1, iorw=1; ioaddr 00 acks the
// data register (clears rda), 01 acks status (clears ferr/oerr). No stall, no
// wait states; any flag set in the same clk takes priority over the clear.
module spart_rx #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       rx,
  spart_rx_if.slave  bus,
  output logic [1:0] fsm_state
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s;
  logic [TW-1:0]          tick_cnt;
  logic [2:0]             bit_cnt;
  logic [7:0]             shreg;
  logic [7:0]             data_q;
  logic                   rda_q;
  logic                   ferr_q;
  logic                   oerr_q;
  logic                   rd_data;
  logic                   rd_stat;
  logic                   complete;

  assign rx_s     = sync[SYNC_STAGES-1];
  assign rd_data  = bus.iocs && bus.iorw && (bus.ioaddr == 2'b00);
  assign rd_stat  = bus.iocs && bus.iorw && (bus.ioaddr == 2'b01);
  assign complete = (state == STOP) && enable && (tick_cnt == TICK_LAST);

  assign bus.rx_data = data_q;
  assign bus.rda     = rda_q;
  assign bus.ferr    = ferr_q;
  assign bus.oerr    = oerr_q;
  assign fsm_state   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '1;
    else        sync <= {sync[SYNC_STAGES-2:0], rx};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      data_q   <= '0;
      rda_q    <= 1'b0;
      ferr_q   <= 1'b0;
      oerr_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state    <= START;
            tick_cnt <= '0;
          end
        end
        START: begin
          if (enable) begin
            if (tick_cnt == TICK_HALF) begin
              // A line that is high again mid start bit was a glitch.
              state    <= rx_s ? IDLE : DATA;
              tick_cnt <= '0;
              bit_cnt  <= '0;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (enable) begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              shreg    <= {rx_s, shreg[7:1]};
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state   <= STOP;
                bit_cnt <= '0;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (enable) begin
            if (tick_cnt == TICK_LAST) begin
              state    <= IDLE;
              tick_cnt <= '0;
              data_q   <= shreg;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (complete)     rda_q <= 1'b1;
      else if (rd_data) rda_q <= 1'b0;

      if (complete && !rx_s) ferr_q <= 1'b1;
      else if (rd_stat)      ferr_q <= 1'b0;

      // A data read landing on the completion clk consumes the old byte, so no overrun.
      if (complete && rda_q && !rd_data) oerr_q <= 1'b1;
      else if (rd_stat)                  oerr_q <= 1'b0;
    end
  end

endmodule
